// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
package fifo_pkg;

    localparam int DATA_SIZE = 8;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Read-side bundle: FIFO read port plus the output valid/ready stream.
// The m_count signal exists only when RD_STREAM_CNT_EN is defined.
interface fifo_rd_stream_if
    import fifo_pkg::*;
#(
    parameter int data_size = DATA_SIZE
);

    logic                 fifo_empty;
    logic [data_size-1:0] fifo_data;
    logic                 fifo_rd_en;
    logic                 m_valid;
    logic                 m_ready;
    logic [data_size-1:0] m_data;
`ifdef RD_STREAM_CNT_EN
    logic [CNT_W-1:0]     m_count;

    modport master (input  fifo_empty, fifo_data, m_ready,
                    output fifo_rd_en, m_valid, m_data, m_count);
    modport slave  (output fifo_empty, fifo_data, m_ready,
                    input  fifo_rd_en, m_valid, m_data, m_count);
`else
    modport master (input  fifo_empty, fifo_data, m_ready,
                    output fifo_rd_en, m_valid, m_data);
    modport slave  (output fifo_empty, fifo_data, m_ready,
                    input  fifo_rd_en, m_valid, m_data);
`endif

endinterface

// File: rtl/fifo_rd_stream_buf2.sv
// Two-entry output buffer: head/tail pointers, occupancy state and a
// registered output word that always shows the next-cycle head entry.
module stream_buf2
    import fifo_pkg::*;
#(
    parameter int data_size = DATA_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr,
    input  logic [data_size-1:0] i_wdata,
    input  logic                 i_pop,
    output occ_e                 o_occ,
    output logic                 o_valid,
    output logic [data_size-1:0] o_data
);

    occ_e                 r_occ, w_occ_next;
    logic                 r_head, w_head_next, w_tail;
    logic [data_size-1:0] r_mem [2];
    logic [data_size-1:0] r_data, w_data_next;
    logic [2:0]           w_sum;

    // With two words stored the tail aliases the head; that slot is only
    // written together with a pop, so the live word is never overwritten.
    assign w_tail = r_head ^ (r_occ == OCC_ONE);

    always_comb begin
        w_sum       = 3'(r_occ) + 3'(i_wr) - 3'(i_pop);
        w_occ_next  = r_occ;
        case (w_sum)
            3'd0:    w_occ_next = OCC_EMPTY;
            3'd1:    w_occ_next = OCC_ONE;
            default: w_occ_next = OCC_TWO;
        endcase
        w_head_next = r_head ^ i_pop;
        w_data_next = r_mem[w_head_next];
        if (i_wr && (w_tail == w_head_next))
            w_data_next = i_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ    <= OCC_EMPTY;
            r_head   <= 1'b0;
            r_data   <= '0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
        end else begin
            r_occ  <= w_occ_next;
            r_head <= w_head_next;
            r_data <= w_data_next;
            if (i_wr)
                r_mem[w_tail] <= i_wdata;
        end
    end

    assert property (@(posedge clk) disable iff (rst) w_sum <= 3'd2);

    assign o_occ   = r_occ;
    assign o_valid = (r_occ != OCC_EMPTY);
    assign o_data  = r_data;

endmodule

// File: rtl/fifo_rd_stream.sv
// FIFO read-side stream adapter: issues reads, tracks the in-flight word and
// feeds a 2-entry buffer. Optional pop counter under RD_STREAM_CNT_EN.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int data_size = DATA_SIZE
) (
    input logic              rd_clk,
    input logic              rrst,
    fifo_rd_stream_if.master bus
);

    logic                 r_inflight;
    logic                 w_pop, w_rd_en, w_valid;
    logic [1:0]           w_pending;
    logic [data_size-1:0] w_data;
    occ_e                 w_occ;

    assign w_pending = 2'(w_occ) + 2'(r_inflight);
    assign w_pop     = w_valid & bus.m_ready;
    // A pop in the same cycle frees the slot the new read will land in.
    assign w_rd_en   = ~rrst & ~bus.fifo_empty & ((w_pending < 2'd2) | w_pop);

    always_ff @(posedge rd_clk or posedge rrst) begin
        if (rrst) r_inflight <= 1'b0;
        else      r_inflight <= w_rd_en;
    end

    stream_buf2 #(.data_size(data_size)) u_buf (
        .clk     (rd_clk),
        .rst     (rrst),
        .i_wr    (r_inflight),
        .i_wdata (bus.fifo_data),
        .i_pop   (w_pop),
        .o_occ   (w_occ),
        .o_valid (w_valid),
        .o_data  (w_data)
    );

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_valid    = w_valid;
    assign bus.m_data     = w_data;

`ifdef RD_STREAM_CNT_EN
    logic [CNT_W-1:0] r_count;

    always_ff @(posedge rd_clk or posedge rrst) begin
        if (rrst)       r_count <= '0;
        else if (w_pop) r_count <= r_count + 1'b1;
    end

    assign bus.m_count = r_count;
`endif

endmodule
